// File: rtl/mk_bsv_pkg.sv
// Shared constants, register map and helpers for the XDMA descriptor-bypass
// control block.
package mk_bsv_pkg;

  localparam int DATA_W      = 256;
  localparam int KEEP_W      = 32;
  localparam int AXIL_W      = 32;
  localparam int DESC_ADDR_W = 64;
  localparam int DESC_LEN_W  = 28;
  localparam int DESC_CTL_W  = 16;

  localparam logic [AXIL_W-1:0]     ID_VALUE = 32'h5244_4D41;
  // stop | completed | EOP
  localparam logic [DESC_CTL_W-1:0] DESC_CTL = 16'h0013;

  typedef logic [7:0] reg_ofs_t;

  localparam reg_ofs_t REG_ID       = 8'h00;
  localparam reg_ofs_t REG_SCRATCH  = 8'h04;
  localparam reg_ofs_t REG_H2C_BASE = 8'h08;
  localparam reg_ofs_t REG_C2H_BASE = 8'h20;
  localparam reg_ofs_t REG_STATUS   = 8'h38;
  localparam reg_ofs_t REG_BEATS    = 8'h3C;
  localparam reg_ofs_t REG_BYTES    = 8'h40;
  localparam reg_ofs_t REG_PKTS     = 8'h44;
  localparam reg_ofs_t REG_CNT_CLR  = 8'h48;

  // Offsets inside one direction's register group, relative to its base
  localparam reg_ofs_t DIR_SRC_LO   = 8'h00;
  localparam reg_ofs_t DIR_SRC_HI   = 8'h04;
  localparam reg_ofs_t DIR_DST_LO   = 8'h08;
  localparam reg_ofs_t DIR_DST_HI   = 8'h0C;
  localparam reg_ofs_t DIR_LEN      = 8'h10;
  localparam reg_ofs_t DIR_DOORBELL = 8'h14;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] src;
    logic [DESC_ADDR_W-1:0] dst;
    logic [DESC_LEN_W-1:0]  len;
  } desc_t;

  function automatic logic [AXIL_W-1:0] apply_strb(input logic [AXIL_W-1:0]   cur,
                                                   input logic [AXIL_W-1:0]   wdata,
                                                   input logic [AXIL_W/8-1:0] strb);
    logic [AXIL_W-1:0] res;
    res = cur;
    for (int b = 0; b < AXIL_W/8; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [5:0] popcount_keep(input logic [KEEP_W-1:0] keep);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + {5'd0, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mk_bsv_top_axil_reg_slave.sv
// AXI-Lite slave handshake: single outstanding write and read, write strobe
// presented in the acceptance cycle, registered read data.
module axil_reg_slave
  import mk_bsv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_awvalid,
  input  logic [AXIL_W-1:0] i_awaddr,
  output logic              o_awready,
  input  logic              i_wvalid,
  input  logic [AXIL_W-1:0] i_wdata,
  input  logic [3:0]        i_wstrb,
  output logic              o_wready,
  output logic              o_bvalid,
  output logic [1:0]        o_bresp,
  input  logic              i_bready,
  input  logic              i_arvalid,
  input  logic [AXIL_W-1:0] i_araddr,
  output logic              o_arready,
  output logic              o_rvalid,
  output logic [1:0]        o_rresp,
  output logic [AXIL_W-1:0] o_rdata,
  input  logic              i_rready,
  output logic              o_wr_en,
  output logic [AXIL_W-1:0] o_wr_addr,
  output logic [AXIL_W-1:0] o_wr_data,
  output logic [3:0]        o_wr_strb,
  output logic [AXIL_W-1:0] o_rd_addr,
  input  logic [AXIL_W-1:0] i_rd_data
);

  logic              r_run;
  logic              r_bvalid;
  logic              r_rvalid;
  logic [AXIL_W-1:0] r_rdata;
  logic              w_wr_go;
  logic              w_rd_go;

  // r_run keeps every ready low until the first edge after reset release
  assign w_wr_go   = r_run && i_awvalid && i_wvalid && !r_bvalid;
  assign w_rd_go   = o_arready && i_arvalid;

  assign o_awready = w_wr_go;
  assign o_wready  = w_wr_go;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = 2'b00;
  assign o_arready = r_run && !r_rvalid;
  assign o_rvalid  = r_rvalid;
  assign o_rresp   = 2'b00;
  assign o_rdata   = r_rdata;

  assign o_wr_en   = w_wr_go;
  assign o_wr_addr = i_awaddr;
  assign o_wr_data = i_wdata;
  assign o_wr_strb = i_wstrb;
  assign o_rd_addr = i_araddr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_wr_go)       r_bvalid <= 1'b1;
      else if (i_bready) r_bvalid <= 1'b0;
      if (w_rd_go) begin
        r_rvalid <= 1'b1;
        r_rdata  <= i_rd_data;
      end else if (i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mk_bsv_top.sv
// XDMA descriptor-bypass controller: AXI-Lite programmed H2C/C2H descriptors
// issued on doorbell, plus H2C stream beat/byte/packet counters.
module mk_bsv_top
  import mk_bsv_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   xdmaChannel_rawAxiStreamSlave_tvalid,
  input  logic [DATA_W-1:0]      xdmaChannel_rawAxiStreamSlave_tdata,
  input  logic [KEEP_W-1:0]      xdmaChannel_rawAxiStreamSlave_tkeep,
  input  logic                   xdmaChannel_rawAxiStreamSlave_tlast,
  output logic                   xdmaChannel_rawAxiStreamSlave_tready,
  input  logic                   xdmaChannel_h2cDescByp_ready,
  output logic                   xdmaChannel_h2cDescByp_load,
  output logic [DESC_ADDR_W-1:0] xdmaChannel_h2cDescByp_src_addr,
  output logic [DESC_ADDR_W-1:0] xdmaChannel_h2cDescByp_dst_addr,
  output logic [DESC_LEN_W-1:0]  xdmaChannel_h2cDescByp_len,
  output logic [DESC_CTL_W-1:0]  xdmaChannel_h2cDescByp_ctl,
  input  logic                   xdmaChannel_c2hDescByp_ready,
  output logic                   xdmaChannel_c2hDescByp_load,
  output logic [DESC_ADDR_W-1:0] xdmaChannel_c2hDescByp_src_addr,
  output logic [DESC_ADDR_W-1:0] xdmaChannel_c2hDescByp_dst_addr,
  output logic [DESC_LEN_W-1:0]  xdmaChannel_c2hDescByp_len,
  output logic [DESC_CTL_W-1:0]  xdmaChannel_c2hDescByp_ctl,
  input  logic                   axilRegBlock_awvalid,
  input  logic [AXIL_W-1:0]      axilRegBlock_awaddr,
  input  logic [2:0]             axilRegBlock_awprot,
  output logic                   axilRegBlock_awready,
  input  logic                   axilRegBlock_wvalid,
  input  logic [AXIL_W-1:0]      axilRegBlock_wdata,
  input  logic [3:0]             axilRegBlock_wstrb,
  output logic                   axilRegBlock_wready,
  output logic                   axilRegBlock_bvalid,
  output logic [1:0]             axilRegBlock_bresp,
  input  logic                   axilRegBlock_bready,
  input  logic                   axilRegBlock_arvalid,
  input  logic [AXIL_W-1:0]      axilRegBlock_araddr,
  input  logic [2:0]             axilRegBlock_arprot,
  output logic                   axilRegBlock_arready,
  output logic                   axilRegBlock_rvalid,
  output logic [1:0]             axilRegBlock_rresp,
  output logic [AXIL_W-1:0]      axilRegBlock_rdata,
  input  logic                   axilRegBlock_rready
);

  logic              w_wr_en;
  logic [AXIL_W-1:0] w_wr_addr;
  logic [AXIL_W-1:0] w_wr_data;
  logic [3:0]        w_wr_strb;
  logic [AXIL_W-1:0] w_rd_addr;
  logic [AXIL_W-1:0] w_rd_data;
  reg_ofs_t          w_wr_ofs;
  reg_ofs_t          w_rd_ofs;

  logic              r_tready;
  logic [AXIL_W-1:0] r_scratch;
  logic [31:0]       r_beats;
  logic [31:0]       r_bytes;
  logic [31:0]       r_pkts;

  logic [1:0]             w_ready;
  logic [1:0]             w_load;
  logic [1:0]             w_pend;
  logic [1:0][AXIL_W-1:0] w_dir_rd;
  desc_t                  w_desc [2];
  logic                   w_beat;
  logic                   w_cnt_clr;
  logic                   w_unused;

  axil_reg_slave u_axil (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_awvalid (axilRegBlock_awvalid),
    .i_awaddr  (axilRegBlock_awaddr),
    .o_awready (axilRegBlock_awready),
    .i_wvalid  (axilRegBlock_wvalid),
    .i_wdata   (axilRegBlock_wdata),
    .i_wstrb   (axilRegBlock_wstrb),
    .o_wready  (axilRegBlock_wready),
    .o_bvalid  (axilRegBlock_bvalid),
    .o_bresp   (axilRegBlock_bresp),
    .i_bready  (axilRegBlock_bready),
    .i_arvalid (axilRegBlock_arvalid),
    .i_araddr  (axilRegBlock_araddr),
    .o_arready (axilRegBlock_arready),
    .o_rvalid  (axilRegBlock_rvalid),
    .o_rresp   (axilRegBlock_rresp),
    .o_rdata   (axilRegBlock_rdata),
    .i_rready  (axilRegBlock_rready),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data)
  );

  // Only addr[7:2] decodes; protection bits and stream payload are not used
  assign w_wr_ofs = {w_wr_addr[7:2], 2'b00};
  assign w_rd_ofs = {w_rd_addr[7:2], 2'b00};
  assign w_unused = ^{axilRegBlock_awprot, axilRegBlock_arprot, w_wr_addr[31:8], w_wr_addr[1:0],
                      w_rd_addr[31:8], w_rd_addr[1:0], xdmaChannel_rawAxiStreamSlave_tdata};

  assign w_ready = {xdmaChannel_c2hDescByp_ready, xdmaChannel_h2cDescByp_ready};

  for (genvar gd = 0; gd < 2; gd++) begin : g_dir
    localparam reg_ofs_t BASE = (gd == 0) ? REG_H2C_BASE : REG_C2H_BASE;

    desc_t             r_cfg;
    desc_t             r_desc;
    logic              r_pend;
    reg_ofs_t          w_wr_rel;
    reg_ofs_t          w_rd_rel;
    logic [AXIL_W-1:0] w_len_nxt;
    logic [3:0]        w_len_unused;
    logic [AXIL_W-1:0] w_rd_val;
    logic              w_db;

    assign w_wr_rel     = w_wr_ofs - BASE;
    assign w_rd_rel     = w_rd_ofs - BASE;
    assign w_len_nxt    = apply_strb({4'd0, r_cfg.len}, w_wr_data, w_wr_strb);
    assign w_len_unused = w_len_nxt[AXIL_W-1:DESC_LEN_W];
    assign w_db         = w_wr_en && (w_wr_rel == DIR_DOORBELL);
    assign w_load[gd]   = r_pend && w_ready[gd];

    // Issue has priority: a doorbell arriving while pending is dropped
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_cfg  <= '0;
        r_desc <= '0;
        r_pend <= 1'b0;
      end else begin
        if (w_wr_en) begin
          case (w_wr_rel)
            DIR_SRC_LO: r_cfg.src[31:0]  <= apply_strb(r_cfg.src[31:0],  w_wr_data, w_wr_strb);
            DIR_SRC_HI: r_cfg.src[63:32] <= apply_strb(r_cfg.src[63:32], w_wr_data, w_wr_strb);
            DIR_DST_LO: r_cfg.dst[31:0]  <= apply_strb(r_cfg.dst[31:0],  w_wr_data, w_wr_strb);
            DIR_DST_HI: r_cfg.dst[63:32] <= apply_strb(r_cfg.dst[63:32], w_wr_data, w_wr_strb);
            DIR_LEN:    r_cfg.len        <= w_len_nxt[DESC_LEN_W-1:0];
            default: ;
          endcase
        end
        if (w_load[gd]) begin
          r_pend <= 1'b0;
        end else if (w_db && !r_pend) begin
          r_pend <= 1'b1;
          r_desc <= r_cfg;
        end
      end
    end

    always_comb begin
      w_rd_val = '0;
      case (w_rd_rel)
        DIR_SRC_LO: w_rd_val = r_cfg.src[31:0];
        DIR_SRC_HI: w_rd_val = r_cfg.src[63:32];
        DIR_DST_LO: w_rd_val = r_cfg.dst[31:0];
        DIR_DST_HI: w_rd_val = r_cfg.dst[63:32];
        DIR_LEN:    w_rd_val = {4'd0, r_cfg.len};
        default:    w_rd_val = '0;
      endcase
    end

    assign w_pend[gd]   = r_pend;
    assign w_desc[gd]   = r_desc;
    assign w_dir_rd[gd] = w_rd_val;
  end

  assign w_beat    = xdmaChannel_rawAxiStreamSlave_tvalid && r_tready;
  assign w_cnt_clr = w_wr_en && (w_wr_ofs == REG_CNT_CLR) && w_wr_data[0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tready  <= 1'b0;
      r_scratch <= '0;
      r_beats   <= '0;
      r_bytes   <= '0;
      r_pkts    <= '0;
    end else begin
      r_tready <= 1'b1;
      if (w_wr_en && (w_wr_ofs == REG_SCRATCH))
        r_scratch <= apply_strb(r_scratch, w_wr_data, w_wr_strb);
      // Clear beats a coincident stream beat
      if (w_cnt_clr) begin
        r_beats <= '0;
        r_bytes <= '0;
        r_pkts  <= '0;
      end else if (w_beat) begin
        r_beats <= r_beats + 32'd1;
        r_bytes <= r_bytes + {26'd0, popcount_keep(xdmaChannel_rawAxiStreamSlave_tkeep)};
        r_pkts  <= r_pkts + {31'd0, xdmaChannel_rawAxiStreamSlave_tlast};
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_rd_ofs)
      REG_ID:      w_rd_data = ID_VALUE;
      REG_SCRATCH: w_rd_data = r_scratch;
      REG_STATUS:  w_rd_data = {30'd0, w_pend[1], w_pend[0]};
      REG_BEATS:   w_rd_data = r_beats;
      REG_BYTES:   w_rd_data = r_bytes;
      REG_PKTS:    w_rd_data = r_pkts;
      default:     w_rd_data = w_dir_rd[0] | w_dir_rd[1];
    endcase
  end

  assign xdmaChannel_rawAxiStreamSlave_tready = r_tready;

  assign xdmaChannel_h2cDescByp_load     = w_load[0];
  assign xdmaChannel_h2cDescByp_src_addr = w_desc[0].src;
  assign xdmaChannel_h2cDescByp_dst_addr = w_desc[0].dst;
  assign xdmaChannel_h2cDescByp_len      = w_desc[0].len;
  assign xdmaChannel_h2cDescByp_ctl      = DESC_CTL;

  assign xdmaChannel_c2hDescByp_load     = w_load[1];
  assign xdmaChannel_c2hDescByp_src_addr = w_desc[1].src;
  assign xdmaChannel_c2hDescByp_dst_addr = w_desc[1].dst;
  assign xdmaChannel_c2hDescByp_len      = w_desc[1].len;
  assign xdmaChannel_c2hDescByp_ctl      = DESC_CTL;

endmodule

// File: tb/tb_mk_bsv_top.sv
// Directed self-checking bench for mk_bsv_top.
module tb_mk_bsv_top;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         tvalid;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tlast;
  logic         tready;
  logic         h2c_ready, h2c_load;
  logic [63:0]  h2c_src, h2c_dst;
  logic [27:0]  h2c_len;
  logic [15:0]  h2c_ctl;
  logic         c2h_ready, c2h_load;
  logic [63:0]  c2h_src, c2h_dst;
  logic [27:0]  c2h_len;
  logic [15:0]  c2h_ctl;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] keeps [3];
  logic [31:0] rd;

  always #5 CLK = ~CLK;

  mk_bsv_top dut (
    .CLK                                  (CLK),
    .RST_N                                (RST_N),
    .xdmaChannel_rawAxiStreamSlave_tvalid (tvalid),
    .xdmaChannel_rawAxiStreamSlave_tdata  (tdata),
    .xdmaChannel_rawAxiStreamSlave_tkeep  (tkeep),
    .xdmaChannel_rawAxiStreamSlave_tlast  (tlast),
    .xdmaChannel_rawAxiStreamSlave_tready (tready),
    .xdmaChannel_h2cDescByp_ready         (h2c_ready),
    .xdmaChannel_h2cDescByp_load          (h2c_load),
    .xdmaChannel_h2cDescByp_src_addr      (h2c_src),
    .xdmaChannel_h2cDescByp_dst_addr      (h2c_dst),
    .xdmaChannel_h2cDescByp_len           (h2c_len),
    .xdmaChannel_h2cDescByp_ctl           (h2c_ctl),
    .xdmaChannel_c2hDescByp_ready         (c2h_ready),
    .xdmaChannel_c2hDescByp_load          (c2h_load),
    .xdmaChannel_c2hDescByp_src_addr      (c2h_src),
    .xdmaChannel_c2hDescByp_dst_addr      (c2h_dst),
    .xdmaChannel_c2hDescByp_len           (c2h_len),
    .xdmaChannel_c2hDescByp_ctl           (c2h_ctl),
    .axilRegBlock_awvalid                 (awvalid),
    .axilRegBlock_awaddr                  (awaddr),
    .axilRegBlock_awprot                  (awprot),
    .axilRegBlock_awready                 (awready),
    .axilRegBlock_wvalid                  (wvalid),
    .axilRegBlock_wdata                   (wdata),
    .axilRegBlock_wstrb                   (wstrb),
    .axilRegBlock_wready                  (wready),
    .axilRegBlock_bvalid                  (bvalid),
    .axilRegBlock_bresp                   (bresp),
    .axilRegBlock_bready                  (bready),
    .axilRegBlock_arvalid                 (arvalid),
    .axilRegBlock_araddr                  (araddr),
    .axilRegBlock_arprot                  (arprot),
    .axilRegBlock_arready                 (arready),
    .axilRegBlock_rvalid                  (rvalid),
    .axilRegBlock_rresp                   (rresp),
    .axilRegBlock_rdata                   (rdata),
    .axilRegBlock_rready                  (rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit wait_b);
    int n;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    #1;
    n = 0;
    while (!awready && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    check("aw_accept", {62'd0, wready, awready}, 64'h3);
    @(posedge CLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_rise", {63'd0, bvalid}, 64'h1);
    check("bresp", {62'd0, bresp}, 64'h0);
    if (wait_b) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    arvalid = 1'b1; araddr = a;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    @(posedge CLK); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    check("rvalid_rise", {63'd0, rvalid}, 64'h1);
    check("rresp", {62'd0, rresp}, 64'h0);
    d = rdata;
    @(posedge CLK); #1;
  endtask

  initial begin
    keeps[0] = 32'hFFFF_FFFF; keeps[1] = 32'hFFFF_FFFF; keeps[2] = 32'h0000_000F;
    RST_N = 1'b0;
    tvalid = 1'b1; tdata = '0; tkeep = '1; tlast = 1'b1;
    h2c_ready = 1'b1; c2h_ready = 1'b1;
    awvalid = 1'b1; awaddr = 32'h04; awprot = 3'b0; wvalid = 1'b1; wdata = '1; wstrb = 4'hF;
    bready = 1'b1; arvalid = 1'b1; araddr = '0; arprot = 3'b0; rready = 1'b1;

    // Reset state with every request asserted
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tready", {63'd0, tready}, 64'h0);
    check("rst_awready", {62'd0, wready, awready}, 64'h0);
    check("rst_arready", {63'd0, arready}, 64'h0);
    check("rst_bvalid_rvalid", {62'd0, bvalid, rvalid}, 64'h0);
    check("rst_loads", {62'd0, c2h_load, h2c_load}, 64'h0);
    check("rst_h2c_src", h2c_src, 64'h0);
    check("rst_c2h_len", {36'd0, c2h_len}, 64'h0);

    tvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    h2c_ready = 1'b0; c2h_ready = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_tready", {63'd0, tready}, 64'h1);
    check("post_rst_arready", {63'd0, arready}, 64'h1);

    // ID and unmapped reads
    axil_read(32'h00, rd);
    check("id", {32'd0, rd}, 64'h5244_4D41);
    axil_read(32'h50, rd);
    check("unmapped", {32'd0, rd}, 64'h0);
    axil_read(32'h3C, rd);
    check("beats_not_counted_in_reset", {32'd0, rd}, 64'h0);

    // Byte strobes on SCRATCH
    axil_write(32'h04, 32'hFFFF_FFFF, 4'b0101, 1'b1);
    axil_read(32'h04, rd);
    check("scratch_strb", {32'd0, rd}, 64'h00FF_00FF);
    axil_write(32'h00, 32'h1234_5678, 4'hF, 1'b1);
    axil_read(32'h00, rd);
    check("id_ro", {32'd0, rd}, 64'h5244_4D41);

    // H2C descriptor programming and issue
    axil_write(32'h08, 32'h0000_1000, 4'hF, 1'b1);
    axil_write(32'h0C, 32'h0000_0001, 4'hF, 1'b1);
    axil_write(32'h10, 32'h0000_2000, 4'hF, 1'b1);
    axil_write(32'h14, 32'h0000_0000, 4'hF, 1'b1);
    axil_write(32'h18, 32'hFFFF_F100, 4'hF, 1'b1);
    axil_read(32'h18, rd);
    check("len_mask", {32'd0, rd}, 64'h0FFF_F100);
    axil_write(32'h18, 32'h0000_0100, 4'hF, 1'b1);
    axil_write(32'h1C, 32'h0000_0001, 4'hF, 1'b1);
    repeat (5) @(posedge CLK);
    #1;
    check("h2c_load_blocked", {63'd0, h2c_load}, 64'h0);
    axil_read(32'h38, rd);
    check("status_h2c_pending", {32'd0, rd}, 64'h1);
    h2c_ready = 1'b1;
    #1;
    check("h2c_load_high", {63'd0, h2c_load}, 64'h1);
    check("h2c_src", h2c_src, 64'h1_0000_1000);
    check("h2c_dst", h2c_dst, 64'h2000);
    check("h2c_len", {36'd0, h2c_len}, 64'h100);
    check("h2c_ctl", {48'd0, h2c_ctl}, 64'h13);
    @(posedge CLK); #1;
    check("h2c_load_one_cycle", {63'd0, h2c_load}, 64'h0);
    h2c_ready = 1'b0;
    axil_read(32'h38, rd);
    check("status_h2c_clear", {32'd0, rd}, 64'h0);

    // C2H second doorbell while pending is dropped
    axil_write(32'h30, 32'h0000_0010, 4'hF, 1'b1);
    axil_write(32'h34, 32'h0000_0001, 4'hF, 1'b1);
    axil_write(32'h30, 32'h0000_0020, 4'hF, 1'b1);
    axil_write(32'h34, 32'h0000_0001, 4'hF, 1'b1);
    check("c2h_len_kept", {36'd0, c2h_len}, 64'h10);
    axil_read(32'h38, rd);
    check("status_c2h_pending", {32'd0, rd}, 64'h2);

    // Stream counters
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tkeep = keeps[i]; tlast = (i == 2); tdata = {8{$urandom}};
      @(posedge CLK); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    axil_read(32'h3C, rd);
    check("beats", {32'd0, rd}, 64'd3);
    axil_read(32'h40, rd);
    check("bytes", {32'd0, rd}, 64'd68);
    axil_read(32'h44, rd);
    check("pkts", {32'd0, rd}, 64'd1);

    // Counter clear coincident with a beat
    awvalid = 1'b1; awaddr = 32'h48; wvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF;
    tvalid = 1'b1; tkeep = '1; tlast = 1'b1;
    #1;
    check("clr_accept", {63'd0, awready}, 64'h1);
    @(posedge CLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    @(posedge CLK); #1;
    axil_read(32'h3C, rd);
    check("beats_clr", {32'd0, rd}, 64'h0);
    axil_read(32'h40, rd);
    check("bytes_clr", {32'd0, rd}, 64'h0);
    axil_read(32'h44, rd);
    check("pkts_clr", {32'd0, rd}, 64'h0);

    // Reset while C2H pending and a B response outstanding
    bready = 1'b0;
    axil_write(32'h04, 32'h0000_00A5, 4'hF, 1'b0);
    @(posedge CLK); #1;
    check("bvalid_hold", {63'd0, bvalid}, 64'h1);
    RST_N = 1'b0; c2h_ready = 1'b1;
    #1;
    check("arst_bvalid", {63'd0, bvalid}, 64'h0);
    check("arst_ready", {62'd0, tready, arready}, 64'h0);
    check("arst_c2h_load", {63'd0, c2h_load}, 64'h0);
    check("arst_c2h_len", {36'd0, c2h_len}, 64'h0);
    c2h_ready = 1'b0; bready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    axil_read(32'h38, rd);
    check("status_after_rst", {32'd0, rd}, 64'h0);
    axil_read(32'h04, rd);
    check("scratch_after_rst", {32'd0, rd}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mk_bsv_top.md
MK_BSV_TOP -- requirements
Module: mk_bsv_top

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameters: none; data width fixed at 256 bits, keep width 32 bits, AXI-Lite address and data 32 bits.
REQ-003 Ports, clock and reset first (name  dir  width  meaning):
- CLK  in  1  sole clock.
- RST_N  in  1  async active-low reset.
- xdmaChannel_rawAxiStreamSlave_tvalid/tdata/tkeep/tlast  in  1/256/32/1  host-to-card (H2C) stream beat.
- xdmaChannel_rawAxiStreamSlave_tready  out  1  stream accept.
- xdmaChannel_h2cDescByp_ready  in  1  DMA engine accepts an H2C descriptor.
- xdmaChannel_h2cDescByp_load  out  1  H2C descriptor strobe.
- xdmaChannel_h2cDescByp_src_addr/dst_addr/len/ctl  out  64/64/28/16  H2C descriptor fields.
- xdmaChannel_c2hDescByp_ready, _load, _src_addr, _dst_addr, _len, _ctl  same directions and widths as the H2C set, for the card-to-host (C2H) descriptor.
- axilRegBlock_awvalid/awaddr/awprot  in  1/32/3;  axilRegBlock_awready  out  1.
- axilRegBlock_wvalid/wdata/wstrb  in  1/32/4;  axilRegBlock_wready  out  1.
- axilRegBlock_bvalid/bresp  out  1/2;  axilRegBlock_bready  in  1.
- axilRegBlock_arvalid/araddr/arprot  in  1/32/3;  axilRegBlock_arready  out  1.
- axilRegBlock_rvalid/rresp/rdata  out  1/2/32;  axilRegBlock_rready  in  1.

Function
REQ-004 Register map, decoded on addr[7:2], upper bits ignored:
- 0x00 ID: RO, 0x5244_4D41.
- 0x04 SCRATCH: RW.
- 0x08/0x0C H2C_SRC lo/hi: RW.
- 0x10/0x14 H2C_DST lo/hi: RW.
- 0x18 H2C_LEN: RW, bits [27:0].
- 0x1C H2C_DOORBELL: WO.
- 0x20-0x34: C2H_SRC, C2H_DST, C2H_LEN, C2H_DOORBELL, same layout as 0x08-0x1C.
- 0x38 STATUS: RO; bit0 = H2C pending, bit1 = C2H pending.
- 0x3C H2C_BEATS, 0x40 H2C_BYTES, 0x44 H2C_PKTS: RO, 32-bit wrapping counters.
- 0x48 CNT_CLR: WO; writing bit0 = 1 zeroes all three counters.
REQ-005 Unmapped reads SHALL return 0; unmapped or RO writes SHALL be ignored; bresp and rresp SHALL always be 00 (OKAY).
REQ-006 RW registers SHALL honour wstrb per byte; awprot and arprot are ignored.
REQ-007 AXI-Lite write handling:
- awready and wready SHALL be asserted together, only when both awvalid and wvalid are high and no B response is outstanding.
- The register update SHALL happen in that acceptance cycle.
- bvalid SHALL rise the next cycle and hold until bready.
REQ-008 AXI-Lite read handling:
- arready SHALL be high when no R response is outstanding.
- rdata SHALL be registered, with rvalid rising the cycle after acceptance and holding until rready.
- rdata SHALL be stable while rvalid is high.
REQ-009 Read and write channels SHALL operate independently; one outstanding transaction per channel.
REQ-010 Doorbell behaviour:
- A doorbell write sets that direction's pending flag and latches the current SRC/DST/LEN into the descriptor output registers.
- A doorbell write while pending is already set SHALL be dropped.
REQ-011 Descriptor issue:
- load SHALL equal pending AND ready.
- In a cycle where load is high, pending SHALL clear at the next edge.
- Descriptor fields SHALL hold their values until then.
REQ-012 ctl SHALL be constant 0x0013 (stop, completed, EOP) for both directions.
REQ-013 tready SHALL be constant 1 after reset. Per beat with tvalid high:
- BEATS += 1.
- BYTES += popcount(tkeep).
- PKTS += tlast.
REQ-014 A CNT_CLR write coinciding with a stream beat SHALL leave the counters at 0 (clear wins).
REQ-015 A doorbell write and a load in the same cycle for the same direction SHALL leave pending = 0; the new doorbell is dropped per REQ-010.

Reset
REQ-016 While RST_N is low, SHALL drive:
- tready, load, awready, wready, bvalid, arready and rvalid = 0.
- All registers, counters, pending flags and descriptor fields = 0.
REQ-017 Reset deassertion SHALL take effect at the next CLK edge; tready and arready rise in the first cycle after release.

Structure
REQ-018 A shared package SHALL hold the register offsets, the ID constant, the ctl constant 0x0013 and the width constants (256, 32, 64, 28).
REQ-019 The AXI-Lite slave handshake SHALL be one sub-module, axil_reg_slave, exposing a write strobe, address, data and strobes plus a read address and data to the top.

Verification
REQ-020 Reset released, read 0x00 -> rdata 0x5244_4D41, rresp 00; read 0x50 -> 0.
REQ-021 Write SCRATCH 0xFFFF_FFFF with wstrb 0101, then read -> 0x00FF_00FF.
REQ-022 Program H2C_SRC = 0x1_0000_1000, DST = 0x2000, LEN = 0x100, ring the doorbell with ready = 0 for 5 cycles -> STATUS bit0 = 1 and load = 0; raise ready -> load high for exactly 1 cycle with the same fields and ctl 0x0013, then STATUS bit0 = 0.
REQ-023 Send 3 beats (tkeep 0xFFFF_FFFF, 0xFFFF_FFFF, 0x0000_000F, tlast on the 3rd) -> BEATS 3, BYTES 68, PKTS 1.
REQ-024 Write CNT_CLR with a beat in the same cycle -> all counters read 0.
REQ-025 Assert RST_N low while C2H is pending and bvalid is high -> outputs are 0 immediately; after release STATUS reads 0.
